// File: rtl/mult_div_unit_pkg.sv
// Shared multiply/divide definitions: md_op encodings and FSM states.
package md_defs;

    localparam int unsigned XLEN = 32;

    typedef enum logic [2:0] {
        MD_MULT  = 3'd0,
        MD_MULTU = 3'd1,
        MD_DIV   = 3'd2,
        MD_DIVU  = 3'd3,
        MD_MTHI  = 3'd4,
        MD_MTLO  = 3'd5
    } md_op_e;

    typedef enum logic {
        S_IDLE = 1'b0,
        S_BUSY = 1'b1
    } md_state_e;

endpackage

// File: rtl/mult_div_unit.sv
// Multi-cycle MULT/DIV unit with HI/LO registers; the result is computed at accept and held until commit.
// Optional MD_CANCEL_EN adds a cancel input that aborts an in-flight op and suppresses a simultaneous start.
module mult_div_unit
    import md_defs::*;
#(
    parameter int unsigned MULT_CYCLES = 5,
    parameter int unsigned DIV_CYCLES  = 10
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            start,
    input  logic [2:0]      md_op,
    input  logic [XLEN-1:0] a,
    input  logic [XLEN-1:0] b,
`ifdef MD_CANCEL_EN
    input  logic            cancel,
`endif
    output logic            busy,
    output logic [XLEN-1:0] hi,
    output logic [XLEN-1:0] lo
);

    localparam int unsigned MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int unsigned CW         = $clog2(MAX_CYCLES) + 1;

    md_state_e         state_q, state_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic [XLEN-1:0]   hi_d, lo_d;
    logic [XLEN-1:0]   phi_q, phi_d, plo_q, plo_d;
    logic              is_div_q, is_div_d;
    logic              divz_q, divz_d;
    logic              cancel_c;
    logic [CW-1:0]     target;

`ifdef MD_CANCEL_EN
    assign cancel_c = cancel;
`else
    assign cancel_c = 1'b0;
`endif

    // Result datapath; a zero or overflowing divisor is replaced so the divider never sees it.
    logic [2*XLEN-1:0]      prod_s, prod_u;
    logic                   b_zero, div_ovf;
    logic signed [XLEN-1:0] sa, sb, sq, sr;
    logic [XLEN-1:0]        ub, uq, ur;

    assign prod_s  = {{XLEN{a[XLEN-1]}}, a} * {{XLEN{b[XLEN-1]}}, b};
    assign prod_u  = {{XLEN{1'b0}}, a} * {{XLEN{1'b0}}, b};
    assign b_zero  = (b == '0);
    assign div_ovf = (a == {1'b1, {(XLEN-1){1'b0}}}) && (b == '1);
    assign sa      = $signed(a);
    assign sb      = (b_zero || div_ovf) ? $signed(XLEN'(1)) : $signed(b);
    assign sq      = sa / sb;
    assign sr      = sa % sb;
    assign ub      = b_zero ? XLEN'(1) : b;
    assign uq      = a / ub;
    assign ur      = a % ub;

    assign target  = is_div_q ? CW'(DIV_CYCLES) : CW'(MULT_CYCLES);

    // State and result registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            hi       <= '0;
            lo       <= '0;
            phi_q    <= '0;
            plo_q    <= '0;
            is_div_q <= 1'b0;
            divz_q   <= 1'b0;
            busy     <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            hi       <= hi_d;
            lo       <= lo_d;
            phi_q    <= phi_d;
            plo_q    <= plo_d;
            is_div_q <= is_div_d;
            divz_q   <= divz_d;
            busy     <= (state_d == S_BUSY);
        end
    end

    // Next-state: accept in IDLE, count in BUSY, commit at the terminal count unless cancelled.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        hi_d     = hi;
        lo_d     = lo;
        phi_d    = phi_q;
        plo_d    = plo_q;
        is_div_d = is_div_q;
        divz_d   = divz_q;

        unique case (state_q)
            S_IDLE: begin
                if (start && !cancel_c) begin
                    case (md_op)
                        MD_MULT, MD_MULTU: begin
                            {phi_d, plo_d} = (md_op == MD_MULT) ? prod_s : prod_u;
                            is_div_d = 1'b0;
                            divz_d   = 1'b0;
                            cnt_d    = CW'(1);
                            state_d  = S_BUSY;
                        end
                        MD_DIV: begin
                            phi_d    = XLEN'(sr);
                            plo_d    = XLEN'(sq);
                            is_div_d = 1'b1;
                            divz_d   = b_zero;
                            cnt_d    = CW'(1);
                            state_d  = S_BUSY;
                        end
                        MD_DIVU: begin
                            phi_d    = ur;
                            plo_d    = uq;
                            is_div_d = 1'b1;
                            divz_d   = b_zero;
                            cnt_d    = CW'(1);
                            state_d  = S_BUSY;
                        end
                        MD_MTHI: hi_d = a;
                        MD_MTLO: lo_d = a;
                        default: ;
                    endcase
                end
            end
            S_BUSY: begin
                if (cancel_c) begin
                    state_d = S_IDLE;
                end else if (cnt_q >= target) begin
                    state_d = S_IDLE;
                    if (!divz_q) begin
                        hi_d = phi_q;
                        lo_d = plo_q;
                    end
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

endmodule

// File: tb/tb_mult_div_unit.sv
// Self-checking bench for mult_div_unit against a 64-bit arithmetic reference model.
module tb_mult_div_unit;

    localparam int unsigned MC = 5;
    localparam int unsigned DC = 10;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [2:0]  md_op;
    logic [31:0] a, b;
    logic        busy;
    logic [31:0] hi, lo;
`ifdef MD_CANCEL_EN
    logic        cancel;
`endif

    int cmp_cnt = 0;
    int err_cnt = 0;
    logic [31:0] mh, ml;

    mult_div_unit #(.MULT_CYCLES(MC), .DIV_CYCLES(DC)) dut (
        .clk   (clk),
        .reset (reset),
        .start (start),
        .md_op (md_op),
        .a     (a),
        .b     (b),
`ifdef MD_CANCEL_EN
        .cancel(cancel),
`endif
        .busy  (busy),
        .hi    (hi),
        .lo    (lo)
    );

    always #5 clk = ~clk;

    // Reference: architectural effect of one accepted op on HI/LO.
    function automatic void ref_op(input logic [2:0] op, input logic [31:0] x, input logic [31:0] y,
                                   inout logic [31:0] h, inout logic [31:0] l);
        int ix, iy;
        longint sx, sy, p;
        longint unsigned up;
        ix = x; iy = y; sx = ix; sy = iy;
        case (op)
            3'd0: begin p = sx * sy; h = p[63:32]; l = p[31:0]; end
            3'd1: begin up = {32'd0, x} * {32'd0, y}; h = up[63:32]; l = up[31:0]; end
            3'd2: if (y != 0) begin p = sx / sy; l = p[31:0]; p = sx % sy; h = p[31:0]; end
            3'd3: if (y != 0) begin l = x / y; h = x % y; end
            3'd4: h = x;
            3'd5: l = x;
            default: ;
        endcase
    endfunction

    function automatic int op_cycles(input logic [2:0] op);
        if (op <= 3'd1) return MC;
        if (op <= 3'd3) return DC;
        return 0;
    endfunction

    task automatic issue(input logic [2:0] op, input logic [31:0] x, input logic [31:0] y);
        start = 1'b1; md_op = op; a = x; b = y;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b0; start = 1'b0; md_op = '0; a = '0; b = '0;
`ifdef MD_CANCEL_EN
        cancel = 1'b0;
`endif
        repeat (3) @(negedge clk);
        cmp_cnt++;
        if (busy !== 1'b0 || hi !== 32'd0 || lo !== 32'd0) begin
            err_cnt++;
            $display("FAIL reset: busy=%b hi=%h lo=%h expected 0/0/0", busy, hi, lo);
        end
        reset = 1'b1;
        @(negedge clk);
        mh = '0; ml = '0;
    endtask

    task automatic test_directed();
        logic [2:0]  ops [6] = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd2, 3'd3};
        logic [31:0] xa  [6] = '{32'hFFFFFFFE, 32'hFFFFFFFF, 32'hFFFFFFF9, 32'd7, 32'h80000000, 32'd100};
        logic [31:0] xb  [6] = '{32'd3, 32'hFFFFFFFF, 32'd2, 32'd0, 32'hFFFFFFFF, 32'd7};
        logic [31:0] eh  [6] = '{32'hFFFFFFFF, 32'hFFFFFFFE, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'd0, 32'd2};
        logic [31:0] el  [6] = '{32'hFFFFFFFA, 32'h00000001, 32'hFFFFFFFD, 32'hFFFFFFFD, 32'h80000000, 32'd14};
        for (int i = 0; i < 6; i++) begin
            int n;
            int busy_cyc;
            n = op_cycles(ops[i]);
            busy_cyc = 0;
            issue(ops[i], xa[i], xb[i]);
            for (int k = 0; k < n + 2 && busy === 1'b1; k++) begin
                busy_cyc++;
                @(negedge clk);
            end
            cmp_cnt++;
            if (busy_cyc != n) begin
                err_cnt++;
                $display("FAIL directed%0d_latency: busy cycles=%0d expected %0d", i, busy_cyc, n);
            end
            cmp_cnt++;
            if (hi !== eh[i] || lo !== el[i]) begin
                err_cnt++;
                $display("FAIL directed%0d_result: hi=%h lo=%h expected hi=%h lo=%h", i, hi, lo, eh[i], el[i]);
            end
            mh = eh[i]; ml = el[i];
        end
    endtask

    task automatic test_mthi_mtlo();
        start = 1'b1; md_op = 3'd4; a = 32'h12345678; b = '0;
        @(negedge clk);
        cmp_cnt++;
        if (hi !== 32'h12345678 || lo !== ml || busy !== 1'b0) begin
            err_cnt++;
            $display("FAIL mthi: hi=%h lo=%h busy=%b expected hi=12345678 lo=%h busy=0", hi, lo, busy, ml);
        end
        md_op = 3'd5; a = 32'hCAFEBABE;
        @(negedge clk);
        start = 1'b0;
        cmp_cnt++;
        if (hi !== 32'h12345678 || lo !== 32'hCAFEBABE || busy !== 1'b0) begin
            err_cnt++;
            $display("FAIL mtlo: hi=%h lo=%h busy=%b expected hi=12345678 lo=cafebabe busy=0", hi, lo, busy);
        end
        mh = 32'h12345678; ml = 32'hCAFEBABE;
    endtask

    task automatic test_ignore_while_busy();
        issue(3'd0, 32'd3, 32'd4);
        @(negedge clk);
        start = 1'b1; md_op = 3'd5; a = 32'hDEADBEEF;
        @(negedge clk);
        start = 1'b0;
        cmp_cnt++;
        if (lo !== ml || hi !== mh || busy !== 1'b1) begin
            err_cnt++;
            $display("FAIL ignore_mtlo_busy: hi=%h lo=%h busy=%b expected hi=%h lo=%h busy=1", hi, lo, busy, mh, ml);
        end
        repeat (MC - 2) @(negedge clk);
        cmp_cnt++;
        if (hi !== 32'd0 || lo !== 32'd12 || busy !== 1'b0) begin
            err_cnt++;
            $display("FAIL ignore_commit: hi=%h lo=%h busy=%b expected hi=0 lo=c busy=0", hi, lo, busy);
        end
        mh = 32'd0; ml = 32'd12;
    endtask

    task automatic test_random();
        for (int it = 0; it < 40; it++) begin
            logic [2:0]  op;
            logic [31:0] x, y, oh, ol;
            int n;
            op = 3'($urandom_range(0, 7));
            x  = $urandom;
            y  = ($urandom_range(0, 5) == 0) ? 32'd0 :
                 ($urandom_range(0, 2) == 0) ? 32'($urandom_range(1, 20)) : $urandom;
            if ($urandom_range(0, 3) == 0) x = 32'($signed(-$urandom_range(0, 1000)));
            n  = op_cycles(op);
            oh = mh; ol = ml;
            ref_op(op, x, y, mh, ml);
            issue(op, x, y);
            for (int k = 1; k <= n; k++) begin
                cmp_cnt++;
                if (busy !== 1'b1 || hi !== oh || lo !== ol) begin
                    err_cnt++;
                    $display("FAIL rand%0d_busy k=%0d: busy=%b hi=%h lo=%h expected busy=1 hi=%h lo=%h",
                             it, k, busy, hi, lo, oh, ol);
                end
                if (k == 2 && k < n) begin
                    start = 1'b1; md_op = 3'($urandom_range(0, 7)); a = $urandom; b = $urandom;
                end
                @(negedge clk);
                start = 1'b0;
            end
            cmp_cnt++;
            if (busy !== 1'b0 || hi !== mh || lo !== ml) begin
                err_cnt++;
                $display("FAIL rand%0d_result op=%0d a=%h b=%h: busy=%b hi=%h lo=%h expected busy=0 hi=%h lo=%h",
                         it, op, x, y, busy, hi, lo, mh, ml);
            end
        end
    endtask

    task automatic test_reset_mid_op();
        issue(3'd1, 32'hFFFFFFFF, 32'h00000002);
        @(negedge clk);
        #2 reset = 1'b0;
        #1;
        cmp_cnt++;
        if (busy !== 1'b0 || hi !== 32'd0 || lo !== 32'd0) begin
            err_cnt++;
            $display("FAIL reset_mid_immediate: busy=%b hi=%h lo=%h expected 0/0/0", busy, hi, lo);
        end
        @(negedge clk);
        reset = 1'b1;
        mh = '0; ml = '0;
        repeat (MC + 3) @(negedge clk);
        cmp_cnt++;
        if (busy !== 1'b0 || hi !== 32'd0 || lo !== 32'd0) begin
            err_cnt++;
            $display("FAIL reset_mid_nocommit: busy=%b hi=%h lo=%h expected 0/0/0", busy, hi, lo);
        end
    endtask

`ifdef MD_CANCEL_EN
    task automatic test_cancel();
        issue(3'd2, 32'd100, 32'd7);
        repeat (3) @(negedge clk);
        cancel = 1'b1;
        @(negedge clk);
        cancel = 1'b0;
        cmp_cnt++;
        if (busy !== 1'b0 || hi !== mh || lo !== ml) begin
            err_cnt++;
            $display("FAIL cancel: busy=%b hi=%h lo=%h expected busy=0 hi=%h lo=%h", busy, hi, lo, mh, ml);
        end
        repeat (DC) @(negedge clk);
        cmp_cnt++;
        if (hi !== mh || lo !== ml) begin
            err_cnt++;
            $display("FAIL cancel_nocommit: hi=%h lo=%h expected hi=%h lo=%h", hi, lo, mh, ml);
        end
        cancel = 1'b1;
        issue(3'd4, 32'h55555555, 32'd0);
        cancel = 1'b0;
        cmp_cnt++;
        if (hi !== mh || busy !== 1'b0) begin
            err_cnt++;
            $display("FAIL cancel_start: hi=%h busy=%b expected hi=%h busy=0", hi, busy, mh);
        end
        issue(3'd0, 32'd6, 32'hFFFFFFFF);
        repeat (MC) @(negedge clk);
        mh = 32'hFFFFFFFF; ml = 32'hFFFFFFFA;
        cmp_cnt++;
        if (busy !== 1'b0 || hi !== mh || lo !== ml) begin
            err_cnt++;
            $display("FAIL cancel_then_mult: busy=%b hi=%h lo=%h expected busy=0 hi=%h lo=%h", busy, hi, lo, mh, ml);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_directed();
        test_mthi_mtlo();
        test_ignore_while_busy();
        test_random();
        test_reset_mid_op();
`ifdef MD_CANCEL_EN
        test_cancel();
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_cnt, err_cnt);
        $finish;
    end

endmodule
